regfile_dump_reader: RTL
========================

// Module: regfile_dump_reader
// PURPOSE
//  Read-side sequencer for Register_File_32x32. On a start pulse it sweeps a
//  contiguous address window through both read ports (R1/R2, two registers
//  per fetch) and streams each word out on a valid/ready interface.
//  Sits between the register file and a debug/trace consumer; never writes.
// PARAMETERS
//  DATA_W    32  register/data width
//  ADDR_W    6   register-file read address width
//  NUM_REGS  32  registers in window space; addresses wrap modulo NUM_REGS
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       1-cycle request; ignored while busy=1
//  base_addr  in   ADDR_W  first register of window, sampled with start
//  count      in   ADDR_W  words to dump (0..NUM_REGS), sampled with start
//  rd_addr1   out  ADDR_W  to register file R1
//  rd_addr2   out  ADDR_W  to register file R2
//  rd_data1   in   DATA_W  from register file OUT1 (combinational read)
//  rd_data2   in   DATA_W  from register file OUT2 (combinational read)
//  out_data   out  DATA_W  streamed word
//  out_valid  out  1       out_data valid
//  out_ready  in   1       consumer accepts when out_valid&&out_ready
//  out_last   out  1       marks final beat of dump
//  busy       out  1       high from start acceptance to done
//  done       out  1       1-cycle pulse after final beat accepted
// BEHAVIOUR
//  - Reset: state=IDLE; rd_addr1=rd_addr2=0; out_data=0; out_valid=0;
//    out_last=0; busy=0; done=0; internal ptr/remaining/buffers=0.
//  - States: IDLE, FETCH, SEND_A, SEND_B, FIN.
//  - IDLE: start=1 -> latch ptr=base_addr, rem=count; busy=1.
//    count=0 -> FIN directly (no beats). Else rd_addr1=ptr,
//    rd_addr2=(ptr+1)%NUM_REGS registered, -> FETCH.
//  - FETCH (1 cycle): capture rd_data1->bufA, rd_data2->bufB; -> SEND_A.
//  - SEND_A: out_valid=1, out_data=bufA; out_last=(rem==1). Hold all
//    outputs stable while out_ready=0. On accept: rem-=1; rem==0 -> FIN;
//    else -> SEND_B.
//  - SEND_B: out_data=bufB; out_last=(rem==1). On accept: rem-=1;
//    rem==0 -> FIN; else ptr=(ptr+2)%NUM_REGS, drive new addresses,
//    -> FETCH.
//  - FIN: done=1 one cycle, busy=0, out_valid=0 -> IDLE.
//  - Latency: start at edge N -> first out_valid at edge N+2 (one FETCH).
//    Sustained rate with out_ready=1: 2 words per 3 cycles.
//  - Odd count: bufB of final fetch fetched but never emitted.
//  - Wrap: base_addr+count > NUM_REGS wraps to address 0; base_addr >=
//    NUM_REGS reduced modulo NUM_REGS at sampling.
//  - count > NUM_REGS clamps to NUM_REGS.
//  - start while busy: ignored, no effect on in-flight dump.
//  - rst_n low mid-dump: immediate return to reset values; partial dump
//    abandoned, no done pulse.
//  - rd_data must be stable for the FETCH cycle; register-file writes to
//    the window during a dump yield whatever value is present at FETCH.
// CONFIGURATION
//  REGDUMP_CHECKSUM_EN defined: running XOR of every emitted data word;
//    after final data beat, one extra beat out_data=checksum, out_last=1
//    on checksum beat only (not on last data beat); checksum cleared on
//    start. count=0 emits single checksum beat of 0.
//  Undefined: no checksum logic or beat; out_last on final data word.
// TESTING  (register file preloaded reg[i]=2*i)
//  1 base=1,count=4, ready=1 -> beats 2,4,6,8; last on 8; done 1 cycle
//    after; first valid 2 cycles after start.
//  2 base=30,count=4 -> beats 60,62,0,2 (wrap); rd_addr seq 30/31, 0/1.
//  3 base=5,count=3, ready toggles 1,0,0,1.. -> 10,12,14, data held
//    stable while ready=0; no beat lost/duplicated.
//  4 count=0 -> no valid; done pulse 1 cycle after start
//    (with CHECKSUM_EN: one beat 0, last=1).
//  5 rst_n low during SEND_B of count=8 dump -> all outputs reset
//    values next sample; new start afterwards runs cleanly.
//  6 CHECKSUM_EN, base=1,count=3 -> beats 2,4,6, then 2^4^6=0, last on
//    checksum; start pulsed while busy -> ignored.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Read-side sequencer that sweeps a register-file window through R1/R2 and streams it out.
// Optional trailing XOR checksum beat when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_reader #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_SEND_A = 3'd2;
    localparam logic [2:0] S_SEND_B = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;
`ifdef REGDUMP_CHECKSUM_EN
    localparam logic [2:0] S_SEND_C = 3'd5;
    localparam logic [2:0] S_AFTER  = S_SEND_C;
`else
    localparam logic [2:0] S_AFTER  = S_FIN;
`endif

    localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W:0] a);
        logic [ADDR_W:0] r;
        r = a % NREGS;
        return r[ADDR_W-1:0];
    endfunction

    function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W-1:0] c);
        return ({1'b0, c} > NREGS) ? NREGS : {1'b0, c};
    endfunction

    logic [2:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] start_ptr;
    logic [ADDR_W-1:0] next_ptr;
    logic [ADDR_W:0]   rem;
    logic [ADDR_W:0]   start_rem;
    logic [DATA_W-1:0] bufa;
    logic [DATA_W-1:0] bufb;
    logic              accept;

    assign start_ptr = wrap_addr({1'b0, base_addr});
    assign start_rem = clamp_count(count);
    assign next_ptr  = wrap_addr({1'b0, ptr} + (ADDR_W+1)'(2));
    assign accept    = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            rem      <= '0;
            bufa     <= '0;
            bufb     <= '0;
            rd_addr1 <= '0;
            rd_addr2 <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr <= start_ptr;
                        rem <= start_rem;
                        if (start_rem == '0) begin
                            state <= S_AFTER;
                        end else begin
                            rd_addr1 <= start_ptr;
                            rd_addr2 <= wrap_addr({1'b0, start_ptr} + ONE);
                            state    <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    bufa  <= rd_data1;
                    bufb  <= rd_data2;
                    state <= S_SEND_A;
                end
                S_SEND_A: begin
                    if (accept) begin
                        rem   <= rem - ONE;
                        state <= (rem == ONE) ? S_AFTER : S_SEND_B;
                    end
                end
                S_SEND_B: begin
                    if (accept) begin
                        rem <= rem - ONE;
                        if (rem == ONE) begin
                            state <= S_AFTER;
                        end else begin
                            // Advance the pair window; bufB of an odd tail is simply never sent.
                            ptr      <= next_ptr;
                            rd_addr1 <= next_ptr;
                            rd_addr2 <= wrap_addr({1'b0, next_ptr} + ONE);
                            state    <= S_FETCH;
                        end
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                S_SEND_C: begin
                    if (accept) begin
                        state <= S_FIN;
                    end
                end
`endif
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (state == S_IDLE && start) begin
            csum <= '0;
        end else if (accept && state == S_SEND_A) begin
            csum <= csum ^ bufa;
        end else if (accept && state == S_SEND_B) begin
            csum <= csum ^ bufb;
        end
    end

    assign out_valid = (state == S_SEND_A) || (state == S_SEND_B) || (state == S_SEND_C);
    assign out_last  = (state == S_SEND_C);
`else
    assign out_valid = (state == S_SEND_A) || (state == S_SEND_B);
    assign out_last  = ((state == S_SEND_A) || (state == S_SEND_B)) && (rem == ONE);
`endif

    // Data is muxed straight from the buffers, so it stays stable while stalled.
    always_comb begin
        out_data = '0;
        case (state)
            S_SEND_A: out_data = bufa;
            S_SEND_B: out_data = bufb;
`ifdef REGDUMP_CHECKSUM_EN
            S_SEND_C: out_data = csum;
`endif
            default:  out_data = '0;
        endcase
    end

    assign busy = (state != S_IDLE) && (state != S_FIN);
    assign done = (state == S_FIN);

endmodule
